// File: rtl/spi_rdid_ctrl.sv
// rtl/spi_rdid_ctrl.sv - SPI flash RDID engine: CS setup, opcode out, ID bytes in, CS hold, done strobe
// Optional ID plausibility flag (ID_VALID_OUT) is built when RDID_ID_CHECK_EN is defined.
module spi_rdid_ctrl #(
   parameter logic [7:0] CMD_OPCODE      = 8'h9F,
   parameter int         ID_BYTES        = 3,
   parameter int         CS_SETUP_CYCLES = 2,
   parameter int         CS_HOLD_CYCLES  = 2
) (
   input  logic                  CLK_IN,
   input  logic                  RST_N_IN,
   input  logic                  START_IN,
   output logic                  BUSY_OUT,
   output logic                  DONE_OUT,
   output logic [8*ID_BYTES-1:0] ID_OUT,
   output logic                  SPI_CS_N_OUT,
   output logic                  SPI_SCK_OUT,
   output logic                  SPI_MOSI_OUT,
   input  logic                  SPI_MISO_IN
`ifdef RDID_ID_CHECK_EN
   ,
   output logic                  ID_VALID_OUT
`endif
);

   localparam int         ID_W       = 8 * ID_BYTES;
   localparam logic [5:0] CMD_LAST   = 6'd7;
   localparam logic [5:0] BIT_LAST   = 6'(8 * (1 + ID_BYTES) - 1);
   localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP_CYCLES);
   localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT_CMD,
      SHIFT_ID,
      CS_HOLD
   } state_t;

   state_t            state_q, state_nxt;
   logic [3:0]        dly_q, dly_nxt;
   logic [5:0]        bit_q, bit_nxt;
   logic              phase_q, phase_nxt;
   logic [ID_W-1:0]   shift_q, shift_nxt;
   logic [ID_W-1:0]   id_q, id_nxt;
   logic              cs_n_q, cs_n_nxt;
   logic              sck_q, sck_nxt;
   logic              mosi_q, mosi_nxt;
   logic              busy_q, busy_nxt;
   logic              done_q, done_nxt;
   logic [2:0]        op_idx;
`ifdef RDID_ID_CHECK_EN
   logic              id_valid_q, id_valid_nxt;
`endif

   // Opcode bit to present once the current command bit completes.
   assign op_idx = 3'd6 - bit_q[2:0];

   always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         state_q    <= IDLE;
         dly_q      <= '0;
         bit_q      <= '0;
         phase_q    <= 1'b0;
         shift_q    <= '0;
         id_q       <= '0;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef RDID_ID_CHECK_EN
         id_valid_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_nxt;
         dly_q      <= dly_nxt;
         bit_q      <= bit_nxt;
         phase_q    <= phase_nxt;
         shift_q    <= shift_nxt;
         id_q       <= id_nxt;
         cs_n_q     <= cs_n_nxt;
         sck_q      <= sck_nxt;
         mosi_q     <= mosi_nxt;
         busy_q     <= busy_nxt;
         done_q     <= done_nxt;
`ifdef RDID_ID_CHECK_EN
         id_valid_q <= id_valid_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state_q;
      dly_nxt      = dly_q;
      bit_nxt      = bit_q;
      phase_nxt    = phase_q;
      shift_nxt    = shift_q;
      id_nxt       = id_q;
      cs_n_nxt     = cs_n_q;
      sck_nxt      = sck_q;
      mosi_nxt     = mosi_q;
      busy_nxt     = busy_q;
      done_nxt     = 1'b0;
`ifdef RDID_ID_CHECK_EN
      id_valid_nxt = id_valid_q;
`endif
      case (state_q)
         IDLE: begin
            if (START_IN) begin
               state_nxt = CS_SETUP;
               cs_n_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               dly_nxt   = '0;
               shift_nxt = '0;
            end
         end
         CS_SETUP: begin
            if (dly_q == SETUP_LAST) begin
               state_nxt = SHIFT_CMD;
               bit_nxt   = '0;
               phase_nxt = 1'b0;
               sck_nxt   = 1'b0;
               mosi_nxt  = CMD_OPCODE[7];
            end else begin
               dly_nxt = dly_q + 4'd1;
            end
         end
         SHIFT_CMD, SHIFT_ID: begin
            if (!phase_q) begin
               sck_nxt   = 1'b1;
               phase_nxt = 1'b1;
            end else begin
               // Falling SCK edge: MISO is sampled here, next bit is launched.
               sck_nxt   = 1'b0;
               phase_nxt = 1'b0;
               bit_nxt   = bit_q + 6'd1;
               if (state_q == SHIFT_CMD) begin
                  if (bit_q == CMD_LAST) begin
                     state_nxt = SHIFT_ID;
                     mosi_nxt  = 1'b0;
                  end else begin
                     mosi_nxt = CMD_OPCODE[op_idx];
                  end
               end else begin
                  shift_nxt = {shift_q[ID_W-2:0], SPI_MISO_IN};
                  mosi_nxt  = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_nxt = CS_HOLD;
                     dly_nxt   = '0;
                  end
               end
            end
         end
         CS_HOLD: begin
            if (dly_q == HOLD_LAST) begin
               state_nxt = IDLE;
               cs_n_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               id_nxt    = shift_q;
`ifdef RDID_ID_CHECK_EN
               id_valid_nxt = (shift_q != '0) && (shift_q != '1);
`endif
            end else begin
               dly_nxt = dly_q + 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cs_n_nxt  = 1'b1;
            sck_nxt   = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign BUSY_OUT     = busy_q;
   assign DONE_OUT     = done_q;
   assign ID_OUT       = id_q;
   assign SPI_CS_N_OUT = cs_n_q;
   assign SPI_SCK_OUT  = sck_q;
   assign SPI_MOSI_OUT = mosi_q;
`ifdef RDID_ID_CHECK_EN
   assign ID_VALID_OUT = id_valid_q;
`endif

endmodule

// File: tb/tb_spi_rdid_ctrl.sv
// tb/tb_spi_rdid_ctrl.sv - scoreboard bench for spi_rdid_ctrl with a behavioural SPI flash model
module tb_spi_rdid_ctrl;

   localparam int NB   = 3;
   localparam int SU   = 2;
   localparam int HO   = 2;
   localparam int LAT  = 1 + SU + 16 * (1 + NB) + HO;
   localparam int NB4  = 4;
   localparam int LAT4 = 1 + 1 + 16 * (1 + NB4) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start4 = 1'b0;
   logic busy, done, cs_n, sck, mosi, miso;
   logic [23:0] id_out;
   logic busy4, done4, cs_n4, sck4, mosi4, miso4;
   logic [31:0] id_out4;
`ifdef RDID_ID_CHECK_EN
   logic id_valid, id_valid4;
`endif

   spi_rdid_ctrl u_dut (
      .CLK_IN(clk), .RST_N_IN(rst_n), .START_IN(start),
      .BUSY_OUT(busy), .DONE_OUT(done), .ID_OUT(id_out),
      .SPI_CS_N_OUT(cs_n), .SPI_SCK_OUT(sck), .SPI_MOSI_OUT(mosi),
      .SPI_MISO_IN(miso)
`ifdef RDID_ID_CHECK_EN
      , .ID_VALID_OUT(id_valid)
`endif
   );

   spi_rdid_ctrl #(.ID_BYTES(4), .CS_SETUP_CYCLES(1), .CS_HOLD_CYCLES(1)) u_dut4 (
      .CLK_IN(clk), .RST_N_IN(rst_n), .START_IN(start4),
      .BUSY_OUT(busy4), .DONE_OUT(done4), .ID_OUT(id_out4),
      .SPI_CS_N_OUT(cs_n4), .SPI_SCK_OUT(sck4), .SPI_MOSI_OUT(mosi4),
      .SPI_MISO_IN(miso4)
`ifdef RDID_ID_CHECK_EN
      , .ID_VALID_OUT(id_valid4)
`endif
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Flash model: counts SCK rises per CS frame, captures the command, drives ID bits MSB first.
   logic [23:0] flash_id = 24'h202015;
   logic        miso_high = 1'b0;
   logic        miso_r = 1'b0;
   logic [7:0]  cmd_cap = 8'h00;
   int          sck_n = 0;
   assign miso = miso_high ? 1'b1 : miso_r;

   always @(negedge cs_n) sck_n = 0;
   always @(posedge sck) begin
      if (sck_n < 8) begin
         cmd_cap = {cmd_cap[6:0], mosi};
         miso_r  = 1'($urandom);
      end else if (sck_n < 8 * (1 + NB)) begin
         miso_r = flash_id[8 * NB - 1 - (sck_n - 8)];
      end
      sck_n++;
   end

   logic [31:0] flash_id4 = 32'h20201510;
   logic        miso_r4 = 1'b0;
   logic [7:0]  cmd_cap4 = 8'h00;
   int          sck_n4 = 0;
   assign miso4 = miso_r4;

   always @(negedge cs_n4) sck_n4 = 0;
   always @(posedge sck4) begin
      if (sck_n4 < 8) cmd_cap4 = {cmd_cap4[6:0], mosi4};
      else if (sck_n4 < 8 * (1 + NB4)) miso_r4 = flash_id4[8 * NB4 - 1 - (sck_n4 - 8)];
      sck_n4++;
   end

   typedef struct {
      int          done_cyc;
      logic [23:0] id;
      logic        valid;
   } exp_t;
   exp_t sbq[$];

   logic [23:0] last_id = 24'h0;
   bit          id_moved = 1'b0;

   // Monitor: every DONE_OUT pops one expected transaction.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_id  = 24'h0;
         id_moved = 1'b0;
      end else if (done) begin
         if (sbq.size() == 0) begin
            check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            check("id_out", 64'(id_out), 64'(e.id));
            check("sck_rises", 64'(sck_n), 64'(8 * (1 + NB)));
            check("cmd_opcode", 64'(cmd_cap), 64'h9F);
            check("busy_at_done", 64'(busy), 64'h0);
            check("cs_n_at_done", 64'(cs_n), 64'h1);
            check("id_held_during_txn", 64'(id_moved), 64'h0);
`ifdef RDID_ID_CHECK_EN
            check("id_valid", 64'(id_valid), 64'(e.valid));
`endif
         end
         last_id  = id_out;
         id_moved = 1'b0;
      end else if (id_out !== last_id) begin
         id_moved = 1'b1;
      end
   end

   function automatic exp_t make_exp(input int done_cyc, input logic [23:0] id);
      exp_t e;
      e.done_cyc = done_cyc;
      e.id       = id;
      e.valid    = (id != 24'h0) && (id != 24'hFFFFFF);
      return e;
   endfunction

   task automatic wait_idle_queue(input string name);
      int t = 0;
      while (sbq.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (sbq.size() != 0) begin
         check({name, "_timeout"}, 64'(sbq.size()), 64'h0);
         sbq.delete();
      end
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (!done && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!done) check({name, "_timeout"}, 64'h0, 64'h1);
   endtask

   task automatic run_txn(input logic [23:0] id, input bit hi, input bit extra_start);
      flash_id  = id;
      miso_high = hi;
      sbq.push_back(make_exp(cyc + 1 + LAT, hi ? 24'hFFFFFF : id));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'h1);
      check("cs_n_after_start", 64'(cs_n), 64'h0);
      if (extra_start) begin
         repeat (29) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle_queue("txn");
      repeat (1 + $urandom_range(0, 5)) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] rid;
      int          s4;
      repeat (3) @(negedge clk);
      check("rst_cs_n", 64'(cs_n), 64'h1);
      check("rst_sck", 64'(sck), 64'h0);
      check("rst_mosi", 64'(mosi), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_id", 64'(id_out), 64'h0);
`ifdef RDID_ID_CHECK_EN
      check("rst_id_valid", 64'(id_valid), 64'h0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_txn(24'h202015, 1'b0, 1'b0);
      run_txn(24'h202015, 1'b1, 1'b0);
      run_txn(24'h202015, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         rid = 24'($urandom);
         if ($urandom_range(0, 5) == 0) rid = 24'h000000;
         run_txn(rid, 1'b0, 1'b0);
      end

      // START held high: next transaction is sampled the edge after DONE_OUT.
      flash_id  = 24'h202015;
      miso_high = 1'b0;
      begin
         int s;
         s = cyc + 1;
         for (int k = 0; k < 3; k++) begin
            sbq.push_back(make_exp(s + LAT, 24'h202015));
            s = s + LAT + 1;
         end
      end
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_done("b2b");
         @(negedge clk);
         if (k < 2) check("b2b_cs_gap", 64'(cs_n), 64'h0);
         if (k == 1) start = 1'b0;
      end
      wait_idle_queue("b2b");
      repeat (3) @(negedge clk);

      // Reset mid-transaction.
      sbq.push_back(make_exp(cyc + 1 + LAT, 24'h202015));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cs_n", 64'(cs_n), 64'h1);
      check("midrst_sck", 64'(sck), 64'h0);
      check("midrst_id", 64'(id_out), 64'h0);
      check("midrst_busy", 64'(busy), 64'h0);
      sbq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      run_txn(24'h202015, 1'b0, 1'b0);

      // Overridden instance: 4 ID bytes, 1-cycle setup and hold.
      start4 = 1'b1;
      s4 = cyc + 1;
      @(negedge clk);
      start4 = 1'b0;
      begin
         int t = 0;
         while (!done4 && t < 400) begin
            @(negedge clk);
            t++;
         end
      end
      check("p4_done_seen", 64'(done4), 64'h1);
      check("p4_latency", 64'(cyc - s4), 64'(LAT4));
      check("p4_id", 64'(id_out4), 64'h20201510);
      check("p4_sck_rises", 64'(sck_n4), 64'(8 * (1 + NB4)));
      check("p4_cmd", 64'(cmd_cap4), 64'h9F);
`ifdef RDID_ID_CHECK_EN
      check("p4_id_valid", 64'(id_valid4), 64'h1);
`endif
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
